hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. Drives forwarding selects into EX, stall/flush
//  of the IF/ID, ID/EX (flushED, stallE), EX/MEM and MEM/WB registers. Sequences a data-cache-miss
//  freeze with timeout, and keeps saturating stall/flush performance counters.
// PARAMETERS
//  MISS_TIMEOUT  64  cycles in S_MISS without cachereadyM before entering S_FAULT
//  CNT_WIDTH     16  width of the perf counters stallcnt / flushcnt
// PORTS
//  clk          in   1  core clock, all state on posedge
//  rst          in   1  synchronous active-high reset
//  rs1D, rs2D   in   5  source regs in decode
//  rs1E, rs2E   in   5  source regs in execute
//  rdE, rdM, rdW in  5  dest regs in EX/MEM/WB
//  memreadE     in   1  load in execute
//  regwriteM    in   1  MEM-stage instruction writes rd
//  regwriteW    in   1  WB-stage instruction writes rd
//  pcsrcE       in   1  taken branch/jump/jalr resolved in EX
//  cachemissM   in   1  D-cache miss for MEM-stage access
//  cachereadyM  in   1  refill complete, data valid this cycle
//  forwardAE    out  2  ALU A select: 00 RD1E, 01 result W, 10 aluresult M
//  forwardBE    out  2  same for B / store data
//  stallF, stallD, stallE, stallM  out 1 each  hold stage register
//  flushD, flushE, flushW          out 1 each  clear IF/ID, ID/EX (flushED), MEM/WB
//  missfault    out  1  sticky: refill timed out
//  stallcnt     out  CNT_WIDTH  cycles with stallF=1 (saturating)
//  flushcnt     out  CNT_WIDTH  cycles with branch-caused flushE (saturating)
// BEHAVIOUR
//  - Reset: state S_RUN, miss timer 0, missfault 0, counters 0. While rst=1: flushD=flushE=flushW=1,
//    all stalls 0, forwards 00. rst in any state (incl. S_MISS/S_FAULT) -> S_RUN next cycle.
//  - Forwarding (comb, 0 latency): MEM wins: 10 if regwriteM && rdM!=0 && rdM==rs1E; else 01 if
//    regwriteW && rdW!=0 && rdW==rs1E; else 00. B identical on rs2E. x0 never forwarded.
//  - lwstall = memreadE && rdE!=0 && (rdE==rs1D || rdE==rs2D) -> stallF=stallD=1, flushE=1 (1 bubble).
//  - Redirect: pcsrcE -> flushD=flushE=1, stallF=stallD=0; overrides lwstall in the same cycle.
//  - freeze = (state==S_RUN && cachemissM) || state==S_MISS || state==S_FAULT. freeze -> stallF/D/E/M=1,
//    flushW=1, flushD=flushE=0, forwards still computed. Priority: freeze > redirect > lwstall.
//    pcsrcE arriving during freeze is held by frozen EX and acted on the first unfrozen cycle.
//  - FSM: S_RUN -cachemissM && !cachereadyM-> S_MISS (timer=0); miss with cachereadyM in same cycle:
//    no freeze, stay S_RUN. S_MISS: timer++ each cycle; cachereadyM -> S_RUN, freeze drops that same
//    cycle (pipeline advances on that edge); timer==MISS_TIMEOUT-1 without ready -> S_FAULT.
//    S_FAULT: freeze forever, missfault=1, exit only by rst. Ready on timeout cycle: ready wins.
//  - Counters: +1 per cycle in which stallF=1 (resp. redirect-flushE=1), hold at all-ones; update
//    on posedge, visible next cycle. lwstall bubbles do not count in flushcnt.
// STRUCTURE
//  - hazard_pkg: fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}; miss_state_t
//    {S_RUN, S_MISS, S_FAULT}; REG_ZERO=5'd0.
//  - One sub-module sat_counter #(WIDTH) (clk, rst, inc, count), instantiated twice.
//  - Forwarding/lwstall/priority mux combinational; FSM + timer in one always_ff.
// TESTING
//  1 add x5 in M (regwriteM=1,rdM=5) and in W (rdW=5), rs1E=5 -> forwardAE=10; drop M -> 01; rdM=0,rs1E=0 -> 00.
//  2 memreadE=1,rdE=7,rs2D=7 -> 1 cycle stallF=stallD=flushE=1; same cycle pcsrcE=1 -> flushD=1, stallF=0.
//  3 cachemissM=1 at t0, cachereadyM at t0+5 -> stallF..M=1, flushW=1 for t0..t0+4, released at t0+5; stallcnt=5.
//  4 miss with no ready, MISS_TIMEOUT=8 -> S_FAULT after 8 cycles, missfault=1 held; rst=1 -> all cleared next cycle.
//  5 pcsrcE=1 with cachemissM=1 -> no flush during freeze; flushD=flushE=1 on first cycle after ready; flushcnt=1.
//  6 CNT_WIDTH=4, 20 stall cycles -> stallcnt saturates at 15, no wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, miss FSM states,
// and the forwarding-select helper used for both ALU operands.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_MISS,
    S_FAULT
  } miss_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM result is newer than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic fwd_sel_t fwd_sel(input logic       regwrite_m,
                                       input logic [4:0] rd_m,
                                       input logic       regwrite_w,
                                       input logic [4:0] rd_w,
                                       input logic [4:0] rs);
    if (regwrite_m && (rd_m != REG_ZERO) && (rd_m == rs))
      return FWD_MEM;
    else if (regwrite_w && (rd_w != REG_ZERO) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, synchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use stall, branch redirect flush,
// D-cache miss freeze with timeout fault, and saturating stall/flush perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1D,
  input  logic [4:0]           rs2D,
  input  logic [4:0]           rs1E,
  input  logic [4:0]           rs2E,
  input  logic [4:0]           rdE,
  input  logic [4:0]           rdM,
  input  logic [4:0]           rdW,
  input  logic                 memreadE,
  input  logic                 regwriteM,
  input  logic                 regwriteW,
  input  logic                 pcsrcE,
  input  logic                 cachemissM,
  input  logic                 cachereadyM,
  output logic [1:0]           forwardAE,
  output logic [1:0]           forwardBE,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushW,
  output logic                 missfault,
  output logic [CNT_WIDTH-1:0] stallcnt,
  output logic [CNT_WIDTH-1:0] flushcnt
);

  localparam int TW = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;

  miss_state_t     r_state;
  logic [TW-1:0]   r_timer;
  logic            r_missfault;

  logic            w_lwstall;
  logic            w_freeze;
  logic            w_redirect;
  fwd_sel_t        w_fwd_a;
  fwd_sel_t        w_fwd_b;

  assign w_fwd_a = fwd_sel(regwriteM, rdM, regwriteW, rdW, rs1E);
  assign w_fwd_b = fwd_sel(regwriteM, rdM, regwriteW, rdW, rs2E);

  assign w_lwstall = memreadE && (rdE != REG_ZERO) && ((rdE == rs1D) || (rdE == rs2D));

  // Ready in the same cycle as the miss (or while in S_MISS) releases the freeze immediately.
  always_comb begin
    w_freeze = 1'b0;
    unique case (r_state)
      S_RUN:   w_freeze = cachemissM && !cachereadyM;
      S_MISS:  w_freeze = !cachereadyM;
      S_FAULT: w_freeze = 1'b1;
      default: w_freeze = 1'b0;
    endcase
  end

  assign w_redirect = !rst && !w_freeze && pcsrcE;

  // Priority: reset > freeze > redirect > load-use stall.
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushW = 1'b1;
    end else begin
      forwardAE = w_fwd_a;
      forwardBE = w_fwd_b;
      if (w_freeze) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (w_lwstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_timer     <= '0;
      r_missfault <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (cachemissM && !cachereadyM) begin
            r_state <= S_MISS;
            r_timer <= '0;
          end
        end
        S_MISS: begin
          if (cachereadyM) begin
            r_state <= S_RUN;
          end else if (r_timer == TW'(MISS_TIMEOUT - 1)) begin
            r_state     <= S_FAULT;
            r_missfault <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_FAULT: r_missfault <= 1'b1;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign missfault = r_missfault;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stallcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallF),
    .count (stallcnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flushcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_redirect),
    .count (flushcnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus miss/fault/counter sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
  logic       memreadE = 1'b0, regwriteM = 1'b0, regwriteW = 1'b0, pcsrcE = 1'b0;
  logic       cachemissM = 1'b0, cachereadyM = 1'b0;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, missfault;
  logic [3:0] stallcnt, flushcnt;
  logic [6:0] ctl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MISS_TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .memreadE(memreadE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .pcsrcE(pcsrcE), .cachemissM(cachemissM), .cachereadyM(cachereadyM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .missfault(missfault), .stallcnt(stallcnt), .flushcnt(flushcnt)
  );

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       memreadE, regwriteM, regwriteW, pcsrcE, miss, ready;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] a_rs1D, a_rs2D, a_rs1E, a_rs2E, a_rdE, a_rdM, a_rdW,
                              input logic a_mr, a_rwm, a_rww, a_pc, a_miss, a_ready,
                              input logic [1:0] a_fa, a_fb, input logic [6:0] a_ctl);
    vec_t v;
    v.rs1D = a_rs1D; v.rs2D = a_rs2D; v.rs1E = a_rs1E; v.rs2E = a_rs2E;
    v.rdE = a_rdE; v.rdM = a_rdM; v.rdW = a_rdW;
    v.memreadE = a_mr; v.regwriteM = a_rwm; v.regwriteW = a_rww; v.pcsrcE = a_pc;
    v.miss = a_miss; v.ready = a_ready; v.fa = a_fa; v.fb = a_fb; v.ctl = a_ctl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    memreadE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0; pcsrcE = 1'b0;
    cachemissM = 1'b0; cachereadyM = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[16];
  int   nv;
  int   seen;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour, with a forwardable pattern present on the inputs.
    rst = 1'b1;
    regwriteM = 1'b1; rdM = 5'd5; rs1E = 5'd5; memreadE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
    @(negedge clk); #1;
    chk("rst_ctl", 32'(ctl), 32'(7'b0000111));
    chk("rst_fwdA", 32'(forwardAE), 32'd0);
    @(negedge clk); #1;
    chk("rst_stallcnt", 32'(stallcnt), 32'd0);
    chk("rst_flushcnt", 32'(flushcnt), 32'd0);
    chk("rst_missfault", 32'(missfault), 32'd0);
    do_reset();

    nv = 0;
    vecs[nv++] = mk(0,0,5,0,0,5,5, 0,1,1,0,0,0, 2'b10,2'b00,7'b0000000);
    vecs[nv++] = mk(0,0,5,0,0,0,5, 0,0,1,0,0,0, 2'b01,2'b00,7'b0000000);
    vecs[nv++] = mk(0,0,0,0,0,0,0, 0,1,1,0,0,0, 2'b00,2'b00,7'b0000000);
    vecs[nv++] = mk(0,0,0,9,0,9,0, 0,1,0,0,0,0, 2'b00,2'b10,7'b0000000);
    vecs[nv++] = mk(0,0,0,9,0,3,9, 0,1,1,0,0,0, 2'b00,2'b01,7'b0000000);
    vecs[nv++] = mk(0,0,5,0,0,5,0, 0,0,0,0,0,0, 2'b00,2'b00,7'b0000000);
    vecs[nv++] = mk(0,0,8,8,0,8,8, 0,1,1,0,0,0, 2'b10,2'b10,7'b0000000);
    vecs[nv++] = mk(0,7,0,0,7,0,0, 1,0,0,0,0,0, 2'b00,2'b00,7'b1100010);
    vecs[nv++] = mk(0,7,0,0,7,0,0, 1,0,0,1,0,0, 2'b00,2'b00,7'b0000110);
    vecs[nv++] = mk(0,0,0,0,0,0,0, 1,0,0,0,0,0, 2'b00,2'b00,7'b0000000);
    vecs[nv++] = mk(7,0,0,0,7,0,0, 0,0,0,0,0,0, 2'b00,2'b00,7'b0000000);
    vecs[nv++] = mk(0,0,0,0,0,0,0, 0,0,0,1,0,0, 2'b00,2'b00,7'b0000110);
    vecs[nv++] = mk(3,0,0,0,3,0,0, 1,0,0,0,0,0, 2'b00,2'b00,7'b1100010);
    vecs[nv++] = mk(0,0,4,0,0,0,4, 0,0,1,1,1,1, 2'b01,2'b00,7'b0000110);
    vecs[nv++] = mk(2,0,0,6,2,6,0, 1,1,0,1,1,0, 2'b00,2'b10,7'b1111001);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D; rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E;
      rdE = vecs[i].rdE; rdM = vecs[i].rdM; rdW = vecs[i].rdW;
      memreadE = vecs[i].memreadE; regwriteM = vecs[i].regwriteM; regwriteW = vecs[i].regwriteW;
      pcsrcE = vecs[i].pcsrcE; cachemissM = vecs[i].miss; cachereadyM = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_fwdA", i), 32'(forwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fwdB", i), 32'(forwardBE), 32'(vecs[i].fb));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
    end

    // Miss refilled after five frozen cycles.
    do_reset();
    @(negedge clk);
    cachemissM = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("miss_freeze%0d", k), 32'(ctl), 32'(7'b1111001));
    end
    @(negedge clk);
    cachereadyM = 1'b1;
    #1;
    chk("miss_release", 32'(ctl), 32'(7'b0000000));
    @(negedge clk);
    cachemissM = 1'b0; cachereadyM = 1'b0;
    #1;
    chk("miss_stallcnt", 32'(stallcnt), 32'd5);
    chk("miss_back_run", 32'(ctl), 32'(7'b0000000));

    // Refill never arrives: fault after MISS_TIMEOUT cycles in S_MISS, sticky until reset.
    do_reset();
    @(negedge clk);
    cachemissM = 1'b1;
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(negedge clk); #1;
      if (missfault) seen = i;
    end
    chk("fault_latency", 32'(seen), 32'd9);
    cachemissM = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("fault_sticky", 32'(missfault), 32'd1);
    chk("fault_freeze", 32'(ctl), 32'(7'b1111001));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("fault_rst_ctl", 32'(ctl), 32'(7'b0000111));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fault_cleared", 32'(missfault), 32'd0);
    chk("fault_run_ctl", 32'(ctl), 32'(7'b0000000));
    chk("fault_cnt_clr", 32'(stallcnt), 32'd0);

    // Redirect held by frozen EX and taken on the first unfrozen cycle.
    do_reset();
    @(negedge clk);
    cachemissM = 1'b1; pcsrcE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("redir_frozen%0d", k), 32'(ctl), 32'(7'b1111001));
    end
    @(negedge clk);
    cachereadyM = 1'b1;
    #1;
    chk("redir_taken", 32'(ctl), 32'(7'b0000110));
    @(negedge clk);
    clear_inputs();
    #1;
    chk("redir_flushcnt", 32'(flushcnt), 32'd1);

    // Twenty load-use stall cycles saturate a 4-bit counter; bubbles do not count as flushes.
    do_reset();
    @(negedge clk);
    memreadE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
    repeat (14) @(negedge clk);
    #1;
    chk("sat_mid", 32'(stallcnt), 32'd14);
    repeat (6) @(negedge clk);
    #1;
    chk("sat_hold", 32'(stallcnt), 32'd15);
    chk("sat_flushcnt", 32'(flushcnt), 32'd0);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
